specialist_kbd: RTL

- PS/2-to-key-matrix front end that feeds the k580vv55 parallel interface of the Specialist machine.
- Receives PS/2 keyboard frames, tracks make/break codes, and maintains a 6-row × 12-column key-state matrix plus a separate Shift line.
- Answers the CPU's scan through the PPI port pins: column selects come from port A / port C low nibble, and row returns go to port B.
- It sits directly upstream of the PPI inputs `ipb[7:1]` and, in reverse-scan builds, of `ipa`/`ipc[3:0]`.

---
 rtl/specialist_kbd.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/specialist_kbd.sv
// PS/2 keyboard front end for the Specialist PPI: receives scan codes and keeps a 6x12 key matrix plus Shift.
// Optional reverse scan (column return on row select) is enabled by defining SPEC_KBD_REVERSE_EN.
module specialist_kbd #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [11:0] col_sel_n,
    output logic [5:0]  row_out_n,
    output logic        shift_n,
    input  logic [5:0]  row_sel_n,
    output logic [11:0] col_out_n
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

    logic        clk_s1_q, clk_s2_q, clk_s3_q, dat_s1_q, dat_s2_q;
    logic        fall_q, dat_q;
    rx_state_t   state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shreg_q;
    logic        par_q;
    logic [15:0] tmo_q;
    logic        byte_stb;
    logic        ext_q, rel_q, shl_q, shr_q;
    logic [11:0] key_q [6];
    logic [7:0]  map_w;

    // Returns {valid, row[2:0], col[3:0]} for an {ext, scan code} pair.
    function automatic logic [7:0] key_map(input logic [8:0] code);
        key_map = 8'h00;
        case (code)
            9'h05A: key_map = {1'b1, 3'd0, 4'd0};
            9'h066: key_map = {1'b1, 3'd0, 4'd1};
            9'h029: key_map = {1'b1, 3'd0, 4'd2};
            9'h175: key_map = {1'b1, 3'd0, 4'd3};
            9'h172: key_map = {1'b1, 3'd0, 4'd4};
            9'h16B: key_map = {1'b1, 3'd0, 4'd5};
            9'h174: key_map = {1'b1, 3'd0, 4'd6};
            9'h16C: key_map = {1'b1, 3'd0, 4'd7};
            9'h011: key_map = {1'b1, 3'd0, 4'd8};
            9'h00E: key_map = {1'b1, 3'd0, 4'd9};
            9'h05D: key_map = {1'b1, 3'd0, 4'd10};
            9'h061: key_map = {1'b1, 3'd0, 4'd11};
            9'h052: key_map = {1'b1, 3'd1, 4'd0};
            9'h04C: key_map = {1'b1, 3'd1, 4'd1};
            9'h04A: key_map = {1'b1, 3'd1, 4'd2};
            9'h049: key_map = {1'b1, 3'd1, 4'd3};
            9'h041: key_map = {1'b1, 3'd1, 4'd4};
            9'h03A: key_map = {1'b1, 3'd1, 4'd5};
            9'h031: key_map = {1'b1, 3'd1, 4'd6};
            9'h032: key_map = {1'b1, 3'd1, 4'd7};
            9'h02A: key_map = {1'b1, 3'd1, 4'd8};
            9'h021: key_map = {1'b1, 3'd1, 4'd9};
            9'h022: key_map = {1'b1, 3'd1, 4'd10};
            9'h01A: key_map = {1'b1, 3'd1, 4'd11};
            9'h04B: key_map = {1'b1, 3'd2, 4'd0};
            9'h042: key_map = {1'b1, 3'd2, 4'd1};
            9'h03B: key_map = {1'b1, 3'd2, 4'd2};
            9'h033: key_map = {1'b1, 3'd2, 4'd3};
            9'h034: key_map = {1'b1, 3'd2, 4'd4};
            9'h02B: key_map = {1'b1, 3'd2, 4'd5};
            9'h023: key_map = {1'b1, 3'd2, 4'd6};
            9'h01B: key_map = {1'b1, 3'd2, 4'd7};
            9'h01C: key_map = {1'b1, 3'd2, 4'd8};
            9'h014: key_map = {1'b1, 3'd2, 4'd9};
            9'h058: key_map = {1'b1, 3'd2, 4'd10};
            9'h00D: key_map = {1'b1, 3'd2, 4'd11};
            9'h05B: key_map = {1'b1, 3'd3, 4'd0};
            9'h054: key_map = {1'b1, 3'd3, 4'd1};
            9'h04D: key_map = {1'b1, 3'd3, 4'd2};
            9'h044: key_map = {1'b1, 3'd3, 4'd3};
            9'h043: key_map = {1'b1, 3'd3, 4'd4};
            9'h03C: key_map = {1'b1, 3'd3, 4'd5};
            9'h035: key_map = {1'b1, 3'd3, 4'd6};
            9'h02C: key_map = {1'b1, 3'd3, 4'd7};
            9'h02D: key_map = {1'b1, 3'd3, 4'd8};
            9'h024: key_map = {1'b1, 3'd3, 4'd9};
            9'h01D: key_map = {1'b1, 3'd3, 4'd10};
            9'h015: key_map = {1'b1, 3'd3, 4'd11};
            9'h055: key_map = {1'b1, 3'd4, 4'd0};
            9'h04E: key_map = {1'b1, 3'd4, 4'd1};
            9'h045: key_map = {1'b1, 3'd4, 4'd2};
            9'h046: key_map = {1'b1, 3'd4, 4'd3};
            9'h03E: key_map = {1'b1, 3'd4, 4'd4};
            9'h03D: key_map = {1'b1, 3'd4, 4'd5};
            9'h036: key_map = {1'b1, 3'd4, 4'd6};
            9'h02E: key_map = {1'b1, 3'd4, 4'd7};
            9'h025: key_map = {1'b1, 3'd4, 4'd8};
            9'h026: key_map = {1'b1, 3'd4, 4'd9};
            9'h01E: key_map = {1'b1, 3'd4, 4'd10};
            9'h016: key_map = {1'b1, 3'd4, 4'd11};
            9'h078: key_map = {1'b1, 3'd5, 4'd0};
            9'h009: key_map = {1'b1, 3'd5, 4'd1};
            9'h001: key_map = {1'b1, 3'd5, 4'd2};
            9'h00A: key_map = {1'b1, 3'd5, 4'd3};
            9'h083: key_map = {1'b1, 3'd5, 4'd4};
            9'h00B: key_map = {1'b1, 3'd5, 4'd5};
            9'h003: key_map = {1'b1, 3'd5, 4'd6};
            9'h00C: key_map = {1'b1, 3'd5, 4'd7};
            9'h004: key_map = {1'b1, 3'd5, 4'd8};
            9'h006: key_map = {1'b1, 3'd5, 4'd9};
            9'h005: key_map = {1'b1, 3'd5, 4'd10};
            9'h076: key_map = {1'b1, 3'd5, 4'd11};
            default: key_map = 8'h00;
        endcase
    endfunction

    // Synchronisers idle high so reset never fabricates a falling edge; the edge pulse is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            fall_q   <= 1'b0;
            dat_q    <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            fall_q   <= clk_s3_q & ~clk_s2_q;
            dat_q    <= dat_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
            par_q     <= 1'b0;
            tmo_q     <= 16'd0;
        end else begin
            if (state_q == ST_IDLE || fall_q) tmo_q <= 16'd0;
            else                              tmo_q <= tmo_q + 16'd1;

            if (state_q != ST_IDLE && !fall_q && tmo_q == TIMEOUT_CYC) begin
                state_q <= ST_IDLE;
            end else if (fall_q) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!dat_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shreg_q   <= {dat_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= dat_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Strobe shares the cycle of the stop-bit edge pulse; odd parity over data plus parity bit.
    assign byte_stb = (state_q == ST_STOP) && fall_q && dat_q && (^{shreg_q, par_q});
    assign map_w    = key_map({ext_q, shreg_q});

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
            shl_q <= 1'b0;
            shr_q <= 1'b0;
            for (int r = 0; r < 6; r++) key_q[r] <= 12'h000;
        end else if (byte_stb) begin
            if (shreg_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (shreg_q == 8'hF0) begin
                rel_q <= 1'b1;
            end else begin
                if (!ext_q && shreg_q == 8'h12)      shl_q <= ~rel_q;
                else if (!ext_q && shreg_q == 8'h59) shr_q <= ~rel_q;
                else if (map_w[7])                   key_q[map_w[6:4]][map_w[3:0]] <= ~rel_q;
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end
        end
    end

    assign shift_n = ~(shl_q | shr_q);

    always_comb begin
        for (int r = 0; r < 6; r++) row_out_n[r] = ~|(key_q[r] & ~col_sel_n);
    end

`ifdef SPEC_KBD_REVERSE_EN
    always_comb begin
        for (int c = 0; c < 12; c++) begin
            col_out_n[c] = 1'b1;
            for (int r = 0; r < 6; r++) begin
                if (key_q[r][c] && !row_sel_n[r]) col_out_n[c] = 1'b0;
            end
        end
    end
`else
    logic unused_row_sel;
    assign unused_row_sel = ^row_sel_n;
    assign col_out_n      = 12'hFFF;
`endif

endmodule
